// File: rtl/ifetch_queue_pkg.sv
// ---------------------------------------------------------------------------
// ifetch_queue_pkg
// Shared types for the fetch front end.
//   XLEN / ILEN    : default address and instruction widths
//   fetch_entry_t  : one queued {pc, instr} pair handed to the decoder
//   fetch_state_t  : fetch controller state (BOOT after reset, then RUN)
// ---------------------------------------------------------------------------
package ifetch_queue_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    BOOT,
    RUN
  } fetch_state_t;

endpackage

// File: rtl/ifetch_queue_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Circular-buffer queue holding fetched {pc, instr} entries.
//   clk, reset  : clock, synchronous active-high reset
//   clear_i     : drop all entries (pointers and count return to zero)
//   push_i      : write data_i at the tail
//   data_i      : entry to write
//   pop_i       : retire the head entry (ignored when empty)
//   data_o      : head entry, read straight from the storage registers
//   count_o     : number of valid entries
//   full_o      : count_o == DEPTH
//   empty_o     : count_o == 0
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  import ifetch_queue_pkg::*;

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A pop on an empty queue is ignored. A push into a full queue is only
  // accepted when the head leaves in the same cycle, so the count stays put.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Pointer and occupancy bookkeeping. DEPTH is a power of two, so letting
  // the pointers overflow their natural width wraps them modulo DEPTH.
  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the count decides which slots are meaningful.
  always_ff @(posedge clk) begin
    if (do_push && !clear_i && !reset) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// ---------------------------------------------------------------------------
// ifetch_queue
// Decoupled fetch front end: issues word-aligned icache requests, tracks
// in-flight requests, queues returned instructions with their PCs and hands
// them to the decoder. An execute-stage flush redirects fetch and discards
// responses that belong to requests issued before the flush.
//   clk, reset      : clock, synchronous active-high reset
//   reset_adr_i     : boot PC, sampled while reset is high
//   icache_req_v_o  : request valid, held until icache_gnt_i
//   icache_adr_o    : request address
//   icache_gnt_i    : request accepted this cycle
//   icache_rsp_v_i  : in-order response valid
//   icache_instr_i  : response instruction
//   flush_v_q_i     : redirect from execute
//   pc_data_q_i     : redirect target (low two bits ignored)
//   instr_v_q_o     : queue head valid
//   instr_q_o       : queue head instruction
//   pc_q_o          : queue head PC
//   dec_ready_i     : decoder takes the head this cycle
// ---------------------------------------------------------------------------
module ifetch_queue #(
  parameter int unsigned XLEN    = ifetch_queue_pkg::XLEN,
  parameter int unsigned ILEN    = ifetch_queue_pkg::ILEN,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MAX_OUT = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] reset_adr_i,
  output logic            icache_req_v_o,
  output logic [XLEN-1:0] icache_adr_o,
  input  logic            icache_gnt_i,
  input  logic            icache_rsp_v_i,
  input  logic [ILEN-1:0] icache_instr_i,
  input  logic            flush_v_q_i,
  input  logic [XLEN-1:0] pc_data_q_i,
  output logic            instr_v_q_o,
  output logic [ILEN-1:0] instr_q_o,
  output logic [XLEN-1:0] pc_q_o,
  input  logic            dec_ready_i
);
  import ifetch_queue_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned OW = $clog2(MAX_OUT + 1);

  fetch_state_t         state_q, state_d;
  logic [XLEN-1:0]      req_pc_q, req_pc_d;
  logic [XLEN-1:0]      rsp_pc_q, rsp_pc_d;
  logic [OW-1:0]        out_q, out_d;
  logic [OW-1:0]        drop_q, drop_d;

  logic                 run;
  logic                 req_v;
  logic                 gnt_fire;
  logic                 rsp_fire;
  logic                 push;
  logic                 pop;
  logic [OW-1:0]        live;
  logic [XLEN-1:0]      flush_pc;
  logic [XLEN+ILEN-1:0] head;
  logic [CW-1:0]        count;
  logic                 fifo_full;
  logic                 fifo_empty;

  // State register: reset always lands in BOOT, which lasts exactly one
  // cycle so the boot PC is settled before the first request goes out.
  always_ff @(posedge clk) begin
    if (reset) state_q <= BOOT;
    else       state_q <= state_d;
  end

  // Next-state logic: BOOT hands over to RUN, RUN stays until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // Output logic: everything is quiet unless we are in RUN with reset low.
  // A request needs room for its eventual response: queued entries plus
  // live (non-discarded) requests must stay below DEPTH, so a push can never
  // land on a full queue.
  always_comb begin
    run = 1'b0;
    if (!reset && state_q == RUN) run = 1'b1;
    req_v = run & ~flush_v_q_i
          & ((32'(count) + 32'(live)) < DEPTH)
          & (32'(out_q) < MAX_OUT);
    icache_req_v_o = req_v;
    icache_adr_o   = run ? req_pc_q : '0;
    instr_v_q_o    = run & ~fifo_empty;
    instr_q_o      = run ? head[ILEN-1:0] : '0;
    pc_q_o         = run ? head[XLEN+ILEN-1:ILEN] : '0;
  end

  assign live     = out_q - drop_q;
  assign flush_pc = pc_data_q_i & ~XLEN'(3);
  assign gnt_fire = req_v & icache_gnt_i;
  assign rsp_fire = run & icache_rsp_v_i;
  assign push     = rsp_fire & ~flush_v_q_i & (drop_q == '0);
  assign pop      = instr_v_q_o & dec_ready_i & ~flush_v_q_i;

  // PC and request-tracking next state. On a flush every request still in
  // flight becomes stale; a response arriving in the flush cycle itself is
  // one of them, so it is dropped immediately and not counted again.
  always_comb begin
    req_pc_d = req_pc_q;
    rsp_pc_d = rsp_pc_q;
    out_d    = out_q;
    drop_d   = drop_q;
    if (flush_v_q_i) begin
      req_pc_d = flush_pc;
      rsp_pc_d = flush_pc;
      out_d    = out_q - OW'(rsp_fire);
      drop_d   = out_q - OW'(rsp_fire);
    end else begin
      if (gnt_fire) req_pc_d = req_pc_q + XLEN'(4);
      if (push)     rsp_pc_d = rsp_pc_q + XLEN'(4);
      if (rsp_fire && drop_q != '0) drop_d = drop_q - OW'(1);
      case ({gnt_fire, rsp_fire})
        2'b10:   out_d = out_q + OW'(1);
        2'b01:   out_d = out_q - OW'(1);
        default: out_d = out_q;
      endcase
    end
  end

  // PC and counter registers; reset reloads both PCs from the boot address
  // and forgets anything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_pc_q <= reset_adr_i;
      rsp_pc_q <= reset_adr_i;
      out_q    <= '0;
      drop_q   <= '0;
    end else begin
      req_pc_q <= req_pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
    end
  end

  sync_fifo #(
    .WIDTH (XLEN + ILEN),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .clear_i (flush_v_q_i),
    .push_i  (push),
    .data_i  ({rsp_pc_q, icache_instr_i}),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // The credit check must make these impossible.
  assert property (@(posedge clk) disable iff (reset) !(push && fifo_full && !pop));
  assert property (@(posedge clk) disable iff (reset) 32'(out_q) <= MAX_OUT);
  assert property (@(posedge clk) disable iff (reset) !(rsp_fire && out_q == '0));

endmodule

// File: tb/tb_ifetch_queue.sv
// ---------------------------------------------------------------------------
// tb_ifetch_queue
// Directed bench for ifetch_queue with a small icache responder model and a
// scoreboard of expected {pc, instr} pairs.
// ---------------------------------------------------------------------------
module tb_ifetch_queue;
  import ifetch_queue_pkg::*;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned MAX_OUT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] reset_adr_i;
  logic        icache_req_v_o;
  logic [31:0] icache_adr_o;
  logic        icache_gnt_i;
  logic        icache_rsp_v_i;
  logic [31:0] icache_instr_i;
  logic        flush_v_q_i;
  logic [31:0] pc_data_q_i;
  logic        instr_v_q_o;
  logic [31:0] instr_q_o;
  logic [31:0] pc_q_o;
  logic        dec_ready_i;

  always #5 clk = ~clk;

  ifetch_queue #(
    .XLEN    (32),
    .ILEN    (32),
    .DEPTH   (DEPTH),
    .MAX_OUT (MAX_OUT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .reset_adr_i    (reset_adr_i),
    .icache_req_v_o (icache_req_v_o),
    .icache_adr_o   (icache_adr_o),
    .icache_gnt_i   (icache_gnt_i),
    .icache_rsp_v_i (icache_rsp_v_i),
    .icache_instr_i (icache_instr_i),
    .flush_v_q_i    (flush_v_q_i),
    .pc_data_q_i    (pc_data_q_i),
    .instr_v_q_o    (instr_v_q_o),
    .instr_q_o      (instr_q_o),
    .pc_q_o         (pc_q_o),
    .dec_ready_i    (dec_ready_i)
  );

  // One granted request on its way through the icache model. stale marks a
  // request issued before a flush, dead one issued before a reset.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    bit          stale;
    bit          dead;
    int          due;
  } flight_t;

  flight_t      pipe[$];
  fetch_entry_t expQ[$];

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          popCount = 0;
  bit          modelRun = 1'b0;
  bit          gntKnob = 1'b1;
  bit          readyKnob = 1'b1;
  bit          rspHold = 1'b0;
  bit          randomKnobs = 1'b0;
  bit          rspDriven;
  logic [31:0] nextPc;
  logic        sReqV, sInstrV;
  logic [31:0] sAdr, sPc, sInstr;

  function automatic logic [31:0] instrFor(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic int countOuts();
    int n = 0;
    foreach (pipe[i]) if (!pipe[i].dead) n++;
    return n;
  endfunction

  function automatic int countLive();
    int n = 0;
    foreach (pipe[i]) if (!pipe[i].dead && !pipe[i].stale) n++;
    return n;
  endfunction

  // Single comparison point: counts the check and reports any difference.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs just after the falling edge, sample and
  // check outputs 1ns later, update the model, then step to the next
  // falling edge.
  task automatic applyStimulus(input bit rst, input bit fl, input logic [31:0] flPc);
    fetch_entry_t e;
    flight_t      f;
    bit           expReqV, expInstrV;
    reset       = rst;
    flush_v_q_i = fl;
    pc_data_q_i = flPc;
    icache_gnt_i = randomKnobs ? ($urandom_range(0, 3) != 0) : gntKnob;
    dec_ready_i  = randomKnobs ? ($urandom_range(0, 1) != 0) : readyKnob;
    rspDriven = !rspHold && (pipe.size() > 0) && (pipe[0].due <= cyc);
    icache_rsp_v_i = rspDriven;
    icache_instr_i = rspDriven ? pipe[0].data : 32'hDEAD_BEEF;
    #1;
    sReqV = icache_req_v_o; sAdr = icache_adr_o;
    sInstrV = instr_v_q_o; sPc = pc_q_o; sInstr = instr_q_o;

    expReqV = modelRun && !rst && !fl
              && ((expQ.size() + countLive()) < DEPTH) && (countOuts() < MAX_OUT);
    expInstrV = modelRun && !rst && (expQ.size() > 0);
    checkOutput("req_v", 64'(sReqV), 64'(expReqV));
    checkOutput("instr_v", 64'(sInstrV), 64'(expInstrV));
    if (!modelRun || rst) begin
      checkOutput("idle_adr", 64'(sAdr), 64'h0);
      checkOutput("idle_pc", 64'(sPc), 64'h0);
    end

    // Decoder pop
    if (expInstrV && sInstrV && dec_ready_i && !fl) begin
      e = expQ.pop_front();
      checkOutput("head_pc", 64'(sPc), 64'(e.pc));
      checkOutput("head_instr", 64'(sInstr), 64'(e.instr));
      popCount++;
    end
    // icache response
    if (rspDriven) begin
      f = pipe.pop_front();
      if (!rst && modelRun && !fl && !f.stale && !f.dead)
        expQ.push_back('{pc: f.pc, instr: instrFor(f.pc)});
    end
    // icache grant
    if (!rst && sReqV && icache_gnt_i) begin
      checkOutput("req_adr", 64'(sAdr), 64'(nextPc));
      pipe.push_back('{pc: nextPc, data: instrFor(sAdr), stale: 1'b0, dead: 1'b0, due: cyc + 1});
      nextPc = nextPc + 32'd4;
    end
    // Redirects
    if (rst) begin
      foreach (pipe[i]) pipe[i].dead = 1'b1;
      expQ.delete();
      nextPc = reset_adr_i;
      modelRun = 1'b0;
    end else begin
      if (fl) begin
        foreach (pipe[i]) pipe[i].stale = 1'b1;
        expQ.delete();
        nextPc = flPc & ~32'd3;
      end
      modelRun = 1'b1;
    end

    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic waitValid(input string tag, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
      if (sInstrV) found = 1'b1;
    end
    checkOutput(tag, 64'(found), 64'h1);
  endtask

  initial begin
    reset = 1'b1; reset_adr_i = 32'h8000_0000; icache_gnt_i = 1'b0;
    icache_rsp_v_i = 1'b0; icache_instr_i = '0; flush_v_q_i = 1'b0;
    pc_data_q_i = '0; dec_ready_i = 1'b0; nextPc = 32'h8000_0000;
    @(negedge clk);

    // Boot from 0x8000_0000; first valid head three cycles after release
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("reset_req_v", 64'(sReqV), 64'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("boot_early_valid", 64'(sInstrV), 64'h0);
    end
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("boot_first_valid", 64'(sInstrV), 64'h1);
    checkOutput("boot_first_pc", 64'(sPc), 64'h8000_0000);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 32'h0);

    // Backpressure from address 0: exactly DEPTH entries queue up
    reset_adr_i = 32'h0;
    readyKnob = 1'b0;
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("bp_req_v", 64'(sReqV), 64'h0);
    checkOutput("bp_count", 64'(expQ.size()), 64'(DEPTH));
    checkOutput("bp_head_pc", 64'(sPc), 64'h0);

    // Drain in order while grants are withheld: address held at 0x10
    gntKnob = 1'b0;
    readyKnob = 1'b1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
      if (i < 4) begin
        checkOutput("drain_valid", 64'(sInstrV), 64'h1);
        checkOutput("drain_pc", 64'(sPc), 64'(4 * i));
      end
      if (i >= 1) begin
        checkOutput("stall_req_v", 64'(sReqV), 64'h1);
        checkOutput("stall_adr", 64'(sAdr), 64'h10);
      end
    end

    // Two requests in flight, responses held back, then flush to 0x201
    gntKnob = 1'b1;
    rspHold = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("max_out_reached", 64'(countOuts()), 64'(MAX_OUT));
    checkOutput("max_out_req_v", 64'(sReqV), 64'h0);
    applyStimulus(1'b0, 1'b1, 32'h0000_0201);
    rspHold = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("flush_cleared", 64'(sInstrV), 64'h0);
    waitValid("flush_valid_seen", 12);
    checkOutput("flush_first_pc", 64'(sPc), 64'h200);
    checkOutput("flush_first_instr", 64'(sInstr), 64'(instrFor(32'h200)));

    // Flush coincident with a response and a pop
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("coinc_setup", 64'((countOuts() == 1) && (pipe[0].due <= cyc) && (expQ.size() > 0)), 64'h1);
    applyStimulus(1'b0, 1'b1, 32'h200);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("coinc_cleared", 64'(sInstrV), 64'h0);
    checkOutput("coinc_req_v", 64'(sReqV), 64'h1);
    checkOutput("coinc_adr", 64'(sAdr), 64'h200);

    // Random ready/grant stream wrapping the queue several times
    randomKnobs = 1'b1;
    begin
      int startPops = popCount;
      for (int i = 0; i < 300 && (popCount - startPops) < (3 * DEPTH + 1); i++)
        applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("wrap_stream_done", 64'((popCount - startPops) >= (3 * DEPTH + 1)), 64'h1);
    end
    randomKnobs = 1'b0;
    gntKnob = 1'b1;
    readyKnob = 1'b1;
    rspHold = 1'b1;
    for (int i = 0; i < 20 && countOuts() < MAX_OUT; i++) applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("reset_setup_out", 64'(countOuts()), 64'(MAX_OUT));

    // Reset with two requests in flight; their responses land in reset/BOOT
    reset_adr_i = 32'h4000_0000;
    rspHold = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("stale_drained", 64'(pipe.size()), 64'h0);
    waitValid("restart_valid_seen", 12);
    checkOutput("restart_first_pc", 64'(sPc), 64'h4000_0000);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
